// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared types and helpers for the sliced carry-lookahead adder controller.
//   state_t    : controller FSM encoding (IDLE, RUN, DONE)
//   nslices()  : number of SLICE-bit slices needed to cover WIDTH bits
//   cnt_width(): width of a counter that indexes n slices (at least 1 bit)
// ---------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslices(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_slice.sv
// ---------------------------------------------------------------------------
// cla_slice
// Purely combinational SLICE-bit carry-lookahead adder slice.
// Ports:
//   x, y : SLICE-bit operand slices
//   ci   : carry into bit 0 of the slice
//   s    : SLICE-bit slice sum
//   co   : carry out of the top bit of the slice
// Every internal carry is formed directly from the generate/propagate terms
// and ci, so no carry ripples through the slice bit by bit.
// ---------------------------------------------------------------------------
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;
    logic             term;
    logic             prod;

    assign p = x ^ y;
    assign g = x & y;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]ci
    always_comb begin
        c    = '0;
        term = 1'b0;
        prod = 1'b0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            prod = ci;
            for (int j = 0; j <= i; j++) begin
                prod = prod & p[j];
            end
            term = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                term = term | prod;
            end
            c[i+1] = term;
        end
    end

    assign s  = p ^ c[SLICE-1:0];
    assign co = c[SLICE];

endmodule

// File: rtl/cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl
// Adds two WIDTH-bit operands by reusing one SLICE-bit lookahead slice over
// WIDTH/SLICE consecutive cycles; the inter-slice carry is held in a register.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake; a, b, cin sampled on accept
//   out_valid / out_ready : result handshake; sum, cout, ovf held until taken
//   busy                  : high while an operation is in RUN or DONE
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high, last result held on outputs
// RUN   | one slice per cycle, counter selects the slice, carry registered
// DONE  | result valid, waiting for out_ready
// ---------------------------------------------------------------------------
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICES = nslices(WIDTH, SLICE);
    localparam int CW      = cnt_width(NSLICES);
    localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

    if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_params
        $fatal(1, "cla_seq_ctrl: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic             last_slice;

    assign slice_x    = a_q[int'(cnt_q)*SLICE +: SLICE];
    assign slice_y    = b_q[int'(cnt_q)*SLICE +: SLICE];
    assign last_slice = (cnt_q == LAST);

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready)    state_d = RUN;
            RUN:     if (last_slice)              state_d = DONE;
            DONE:    if (out_valid && out_ready)  state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Output decode; out_valid comes straight from the state flops
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q)*SLICE +: SLICE] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_slice) begin
                    cout_d = slice_co;
                    // slice_s[SLICE-1] is the freshly computed sum MSB
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (slice_s[SLICE-1] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
module tb_cla_seq_ctrl;

    localparam int WIDTH   = 16;
    localparam int SLICE   = 4;
    localparam int LATENCY = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cla_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
        logic [WIDTH:0] t;
        exp_t           e;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        sb.push_back(e);
    endtask

    // One full operation: accept, measure latency, optional backpressure with
    // a competing request, then the result handshake and return to IDLE.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c, input int hold, input logic poke);
        int   cycles;
        exp_t e;
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_i      = x;
        b_i      = y;
        cin_i    = c;
        push_expected(x, y, c);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_i      = 16'hDEAD;
        b_i      = 16'hBEEF;
        cin_i    = 1'b0;
        check("busy_in_run", 32'(busy), 32'd1);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(cycles), 32'(LATENCY));
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a_i      = 16'hAAAA;
                b_i      = 16'h5555;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'(e.sum));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
        check("idle_sum_held", 32'(sum), 32'(e.sum));
    endtask

    initial begin
        int stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'h0000);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h00FF, 16'h0F01, 1'b1, 3, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // Reset after two RUN edges: lower two slices already written (0x33).
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = 16'h1111;
        b_i      = 16'h2222;
        cin_i    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("partial_sum", 32'(sum), 32'h0033);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'h0000);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_out_valid", 32'(stale), 32'd0);

        run_op(16'h0002, 16'h0003, 1'b1, 0, 1'b0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
